// File: rtl/fd_skid_buffer.sv
// Two-entry elastic buffer between fetch and decode: a main register feeding decode
// and a skid register absorbing one word of decode backpressure, in strict FIFO order.
module fd_skid_buffer #(
    parameter int IWIDTH = 24,
    parameter int PWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IWIDTH-1:0] instr_i,
    input  logic [PWIDTH-1:0] pc_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [IWIDTH-1:0] instr_o,
    output logic [PWIDTH-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              flush_i,
    output logic [1:0]        count_o
);

    // Handshake: a word moves on a rising edge when valid and ready are both high
    // in that cycle (accept = valid_i & ready_o, consume = valid_o & ready_i);
    // valid is never withdrawn and data never changes while valid and not ready.

    // The state encoding equals the occupancy, so count_o doubles as the FSM state view.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IWIDTH-1:0] main_instr_q, main_instr_d;
    logic [PWIDTH-1:0] main_pc_q, main_pc_d;
    logic [IWIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [PWIDTH-1:0] skid_pc_q, skid_pc_d;

    logic accept;
    logic consume;

    // Outputs depend only on flops, so no input reaches an output combinationally.
    assign ready_o = (state_q != ST_FULL);
    assign valid_o = (state_q != ST_EMPTY);
    assign count_o = state_q;
    assign instr_o = main_instr_q;
    assign pc_o    = main_pc_q;

    assign accept  = valid_i & ready_o;
    assign consume = valid_o & ready_i;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_instr_d = instr_i;
                    main_pc_d    = pc_i;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_instr_d = instr_i;
                    main_pc_d    = pc_i;
                end else if (accept) begin
                    skid_instr_d = instr_i;
                    skid_pc_d    = pc_i;
                    state_d      = ST_FULL;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // The skid word is older than anything fetch can present, so it moves up first.
                if (consume) begin
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    state_d      = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // A redirect kills everything; stale data is left in place behind valid_o=0.
        if (flush_i) begin
            state_d      = ST_EMPTY;
            main_instr_d = main_instr_q;
            main_pc_d    = main_pc_q;
            skid_instr_d = skid_instr_q;
            skid_pc_d    = skid_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fd_skid_buffer.sv
// Directed bench for fd_skid_buffer: the driver pushes each accepted {pc, instr} into
// an expected queue; a negedge monitor compares occupancy, flags and output words.
module tb_fd_skid_buffer;
  localparam int IW = 24;
  localparam int PW = 16;
  localparam int EW = IW + PW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [IW-1:0] instr_i = '0;
  logic [PW-1:0] pc_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [IW-1:0] instr_o;
  logic [PW-1:0] pc_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [1:0]    count_o;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic          mon_en = 1'b0;
  logic          acc;

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  fd_skid_buffer #(.IWIDTH(IW), .PWIDTH(PW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .instr_i (instr_i),
    .pc_i    (pc_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .flush_i (flush_i),
    .count_o (count_o)
  );

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus; acc tells whether the word was taken
  task automatic cyc(input logic v, input logic [PW-1:0] pc, input logic [IW-1:0] ins,
                     input logic rdy, input logic fl, input logic rs, output logic acc_o);
    int pre;
    valid_i = v;
    pc_i    = pc;
    instr_i = ins;
    ready_i = rdy;
    flush_i = fl;
    rst_i   = rs;
    pre     = exp_q.size();
    acc_o   = v && !fl && !rs && (pre < 2);
    @(posedge clk_i);
    if (rs || fl) exp_q.delete();
    else if (acc_o) exp_q.push_back({pc, ins});
    #1;
  endtask

  // fetch model: hold pc/instr until accepted, bounded cycle budget
  task automatic fetch(input logic [PW-1:0] pc, input logic [IW-1:0] ins, input logic rdy);
    logic a;
    a = 1'b0;
    for (int n = 0; n < 40 && !a; n++) cyc(1'b1, pc, ins, rdy, 1'b0, 1'b0, a);
    if (!a) begin
      failures++;
      $display("FAIL fetch_accept_timeout pc=%0h", pc);
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, rdy, 1'b0, 1'b0, acc);
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("count", EW'(count_o), EW'(exp_q.size()));
      chk("ready_o", EW'(ready_o), EW'(exp_q.size() != 2));
      chk("valid_o", EW'(valid_o), EW'(exp_q.size() != 0));
      if (valid_o && exp_q.size() != 0) begin
        chk("out_word", {pc_o, instr_o}, exp_q[0]);
        if (ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    @(posedge clk_i);
    #1;
    // reset then stream
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    mon_en = 1'b1;
    chk("reset_instr", EW'(instr_o), '0);
    chk("reset_pc", EW'(pc_o), '0);
    for (int i = 0; i < 4; i++) fetch(PW'(i), IW'(24'h0000A0 + i), 1'b1);
    // drain to empty, then ready toggles must produce nothing
    idle(1'b1, 1);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // single stall
    fetch(16'd5, 24'h000B05, 1'b1);
    fetch(16'd6, 24'h000B06, 1'b0);
    idle(1'b1, 3);

    // long stall: output held at pc 7, fetch stalls on pc 9
    fetch(16'd7, 24'h000C07, 1'b1);
    fetch(16'd8, 24'h000C08, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'd9, 24'h000C09, 1'b0, 1'b0, 1'b0, acc);
    fetch(16'd9, 24'h000C09, 1'b1);
    fetch(16'd10, 24'h000C0A, 1'b1);
    idle(1'b1, 3);

    // flush when full: 9 and 10 must never appear
    fetch(16'd8, 24'h000D08, 1'b0);
    fetch(16'd9, 24'h000D09, 1'b0);
    cyc(1'b1, 16'd10, 24'h000D0A, 1'b0, 1'b1, 1'b0, acc);
    fetch(16'd20, 24'h000D14, 1'b1);
    idle(1'b1, 2);

    // flush coinciding with a consume in ONE
    fetch(16'h1234, 24'hABCDEF, 1'b1);
    cyc(1'b1, 16'h1235, 24'h123456, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1, 2);

    // back-to-back full-throughput stream with extreme data patterns
    fetch(16'hFFFF, 24'hFFFFFF, 1'b1);
    fetch(16'h0000, 24'h000000, 1'b1);
    fetch(16'hA5A5, 24'h5A5A5A, 1'b1);
    idle(1'b1, 2);

    // reset mid-stall overrides flush and valid
    fetch(16'h0031, 24'h000E31, 1'b0);
    fetch(16'h0032, 24'h000E32, 1'b0);
    cyc(1'b1, 16'h0033, 24'h000E33, 1'b0, 1'b1, 1'b1, acc);
    chk("midreset_instr", EW'(instr_o), '0);
    chk("midreset_pc", EW'(pc_o), '0);
    idle(1'b1, 2);

    @(negedge clk_i);
    chk("queue_empty_at_end", EW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
